io_uart_periph: RTL and testbench

Memory-mapped IO slave on the core's IO port: decodes `IO_memory_addr`, consumes `IO_memory_write`/`IO_memory_writef`, and returns `IO_memory_read`. It holds an LED register and a UART transmitter with a small TX FIFO, so firmware can queue characters without busy-waiting per bit. It sits directly downstream of the pipelined core's M stage. The core samples `IO_memory_read` at the end of the same cycle the load is in M, so the read path is combinational.

---
 rtl/io_uart_periph.sv | 219 +++++++++++++++++++++
 tb/tb_io_uart_periph.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_periph.sv
// Memory-mapped IO slave: LED register plus a UART transmitter fed by a small TX FIFO.
// Read data is combinational so a load in M completes in the same cycle.
module io_uart_periph #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_memory_addr,
  input  logic [31:0] IO_memory_write,
  input  logic        IO_memory_writef,
  output logic [31:0] IO_memory_read,
  output logic [4:0]  leds,
  output logic        uart_tx
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [3:0] IDX_LEDS   = 4'd1;
  localparam logic [3:0] IDX_DATA   = 4'd2;
  localparam logic [3:0] IDX_STATUS = 4'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Address decode: only the word index and the IO-space bit matter.
  logic [3:0] reg_sel;
  logic       led_we;
  logic       push_req;
  logic       status_we;
  logic       unused_bits;

  assign reg_sel   = IO_memory_addr[5:2];
  assign led_we    = IO_memory_writef && (reg_sel == IDX_LEDS);
  assign push_req  = IO_memory_writef && (reg_sel == IDX_DATA);
  assign status_we = IO_memory_writef && (reg_sel == IDX_STATUS);
  assign unused_bits = ^{IO_memory_addr[31:23], IO_memory_addr[21:6],
                         IO_memory_addr[1:0], IO_memory_write[31:8]};

  logic [4:0] leds_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_reg <= '0;
    end else if (led_we) begin
      leds_reg <= IO_memory_write[4:0];
    end
  end

  assign leds = leds_reg;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          overflow_reg;

  assign fifo_full  = (count_reg == COUNT_FULL);
  assign fifo_empty = (count_reg == '0);
  // A full FIFO still accepts a byte when the transmitter drains one on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= IO_memory_write[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (push_req && !push) begin
      overflow_reg <= 1'b1;
    end else if (status_we && IO_memory_write[3]) begin
      overflow_reg <= 1'b0;
    end
  end

  tx_state_t     state_reg;
  tx_state_t     state_next;
  logic [BW-1:0] baud_reg;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_reg;
  logic [2:0]    bit_next;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic          tx_reg;
  logic          tx_next;
  logic          baud_done;

  assign baud_done = (baud_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          baud_next  = BAUD_MAX;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = BAUD_MAX;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = BAUD_MAX;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = BAUD_MAX;
          // Chain straight into the next frame so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The line level is registered from the next state so it changes with the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign uart_tx = tx_reg;

  logic        busy;
  logic [31:0] status_word;

  assign busy        = !fifo_empty || (state_reg != IDLE);
  assign status_word = {20'd0, 4'(count_reg), 4'd0, overflow_reg, busy, fifo_empty, fifo_full};

  always_comb begin
    IO_memory_read = '0;
    if (IO_memory_addr[22]) begin
      case (reg_sel)
        IDX_LEDS:   IO_memory_read = {27'd0, leds_reg};
        IDX_STATUS: IO_memory_read = status_word;
        default:    IO_memory_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_periph.sv
// Randomized scoreboard bench for io_uart_periph: a timeline model predicts each frame's
// byte and start edge; a line monitor decodes uart_tx and checks against the queue.
module tb_io_uart_periph;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        writef = 1'b0;
  logic [31:0] rdata;
  logic [4:0]  leds;
  logic        uart_tx;

  io_uart_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .IO_memory_addr(addr),
    .IO_memory_write(wdata),
    .IO_memory_writef(writef),
    .IO_memory_read(rdata),
    .leds(leds),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  // Reference model: each accepted byte owns a 10-bit-time slot on the line.
  frame_t     exp_q[$];
  int         sched_q[$];
  int         last_end = 0;
  logic       ov_m = 1'b0;
  logic [4:0] leds_m = '0;

  logic mon_samp [FRAME];
  int   mon_start = 0;
  bit   mon_active = 1'b0;
  int   frames_seen = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_count(input int e);
    int n = 0;
    foreach (sched_q[i]) if (sched_q[i] > e) n++;
    return n;
  endfunction

  function automatic bit model_pop_at(input int e);
    foreach (sched_q[i]) if (sched_q[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int e);
    int n;
    logic [31:0] s;
    n = model_count(e);
    s = '0;
    s[0] = (n == DEPTH);
    s[1] = (n == 0);
    s[2] = (e < last_end);
    s[3] = ov_m;
    s[11:8] = 4'(n);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!a[22]) return 32'd0;
    case (a[5:2])
      4'd1:    return {27'd0, leds_m};
      4'd4:    return model_status(cyc);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] io_addr(input logic [3:0] sel);
    return {9'd0, 1'b1, 16'($urandom), sel, 2'($urandom)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    int e;
    int start;
    frame_t f;
    addr   = a;
    wdata  = d;
    writef = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    writef = 1'b0;
    case (a[5:2])
      4'd1: begin
        leds_m = d[4:0];
        $display("write leds 0x%02h at edge %0d", d[4:0], e);
      end
      4'd2: begin
        if (model_count(e - 1) < DEPTH || model_pop_at(e)) begin
          start = (e + 1 > last_end) ? e + 1 : last_end;
          sched_q.push_back(start);
          last_end = start + FRAME;
          f.data  = d[7:0];
          f.start = start;
          exp_q.push_back(f);
          $display("push 0x%02h at edge %0d, frame due at edge %0d", d[7:0], e, start);
        end else begin
          ov_m = 1'b1;
          $display("push 0x%02h at edge %0d dropped (fifo full)", d[7:0], e);
        end
      end
      4'd4: begin
        if (d[3]) ov_m = 1'b0;
        $display("write status 0x%08h at edge %0d", d, e);
      end
      default: $display("write unmapped 0x%08h <- 0x%08h at edge %0d", a, d, e);
    endcase
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr   = a;
    writef = 1'b0;
    #1;
    d = rdata;
    $display("read  0x%08h -> 0x%08h at edge %0d", a, d, cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic io_check(input logic [31:0] a, input string name);
    logic [31:0] exp;
    logic [31:0] d;
    exp = model_read(a);
    do_read(a, d);
    check32(name, d, exp);
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((exp_q.size() != 0 || mon_active || cyc < last_end) && budget < 3000) begin
      step(1);
      budget++;
    end
    checks++;
    if (budget >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_frame();
    logic [7:0] got;
    bit shape_ok;
    frame_t f;
    shape_ok = 1'b1;
    for (int b = 0; b < 10; b++)
      for (int s = 1; s < CPB; s++)
        if (mon_samp[b*CPB+s] !== mon_samp[b*CPB]) shape_ok = 1'b0;
    if (mon_samp[0] !== 1'b0 || mon_samp[FRAME-CPB] !== 1'b1) shape_ok = 1'b0;
    for (int b = 0; b < 8; b++) got[b] = mon_samp[(b+1)*CPB];
    frames_seen++;
    $display("frame 0x%02h started at edge %0d", got, mon_start);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got byte 0x%02h at edge %0d, required no frame", got, mon_start);
    end else begin
      f = exp_q.pop_front();
      check32("frame_byte", {24'd0, got}, {24'd0, f.data});
      check32("frame_start", mon_start, f.start);
      check32("frame_shape", {31'd0, shape_ok}, 32'd1);
    end
  endtask

  // Line monitor: captures each frame cycle by cycle on the falling clock edge.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && uart_tx === 1'b0) begin
          mon_active = 1'b1;
          mon_start  = cyc;
          k = 0;
        end
        if (mon_active) begin
          mon_samp[k] = uart_tx;
          k++;
          if (k == FRAME) begin
            mon_active = 1'b0;
            finish_frame();
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  sel;
    int e;
    int s;
    int fb;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check32("reset_tx", {31'd0, uart_tx}, 32'd1);
    check32("reset_leds", {27'd0, leds}, 32'd0);
    do_read(32'h0040_0010, d);
    check32("reset_status", d, 32'h0000_0002);

    io_write(32'h0040_0004, 32'h0000_001F);
    check32("leds_out", {27'd0, leds}, 32'h1F);
    do_read(32'h0040_0004, d);
    check32("leds_read", d, 32'h0000_001F);

    io_write(32'h0040_0008, 32'h0000_0055);
    e = cyc;
    step(40);
    do_read(32'h0040_0010, d);
    check32("busy_last_stop_cycle", {31'd0, d[2]}, 32'd1);
    do_read(32'h0040_0010, d);
    check32("busy_cleared", d, 32'h0000_0002);
    wait_idle();

    io_write(32'h0040_0008, 32'h41);
    io_write(32'h0040_0008, 32'h42);
    io_write(32'h0040_0008, 32'h43);
    wait_idle();

    for (int i = 0; i < 6; i++) io_write(32'h0040_0008, 32'h60 + i);
    do_read(32'h0040_0010, d);
    check32("overflow_status", d, 32'h0000_040D);
    io_write(32'h0040_0010, 32'h0000_0008);
    io_check(32'h0040_0010, "overflow_cleared");
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0, 1, 2: begin
          int n;
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) io_write(io_addr(4'd2), $urandom);
        end
        3: io_check(io_addr(4'd4), "rand_status");
        4: begin
          io_write(io_addr(4'd1), $urandom);
          check32("rand_leds_out", {27'd0, leds}, {27'd0, leds_m});
          io_check(io_addr(4'd1), "rand_leds_read");
        end
        5: begin
          io_write(io_addr(4'd4), $urandom);
          io_check(io_addr(4'd4), "rand_w1c_status");
        end
        6: begin
          sel = 4'($urandom_range(5, 15));
          if ($urandom_range(0, 1) == 0) sel = 4'($urandom_range(0, 1) * 3);
          io_write(io_addr(sel), $urandom);
          check32("unmapped_leds_out", {27'd0, leds}, {27'd0, leds_m});
          io_check(io_addr(sel), "unmapped_read");
        end
        7: begin
          sel = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd4;
          io_check(io_addr(sel) & ~32'h0040_0000, "non_io_read");
        end
        default: step($urandom_range(0, 60));
      endcase
    end
    wait_idle();
    io_check(32'h0040_0010, "post_random_status");

    io_write(io_addr(4'd2), 32'($urandom_range(0, 255)));
    io_write(io_addr(4'd2), 32'($urandom_range(0, 255)));
    s = exp_q[0].start;
    step(s + 17 - cyc);
    #2;
    reset = 1'b0;
    exp_q.delete();
    sched_q.delete();
    last_end = 0;
    ov_m = 1'b0;
    leds_m = '0;
    #1;
    check32("midframe_reset_tx", {31'd0, uart_tx}, 32'd1);
    addr = 32'h0040_0010;
    #2;
    check32("midframe_reset_status", rdata, 32'h0000_0002);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    fb = frames_seen;
    step(100);
    check32("no_frame_after_reset", frames_seen, fb);
    check32("tx_idle_after_reset", {31'd0, uart_tx}, 32'd1);
    check32("leds_after_reset", {27'd0, leds}, 32'd0);
    do_read(32'h0040_0010, d);
    check32("status_after_reset", d, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
